seq_right_shifter: RTL and testbench

//  Multi-cycle right shifter/rotator with valid/ready handshakes on input and output.
//  - Shifts one bit position per clock, so area stays small for wide operands.
//  - Supports logical shift right, arithmetic shift right and rotate right.
//  - Companion to the combinational left shifter; sits between a producer and consumer
//    of arithmetic operands.

---
 rtl/seq_right_shifter_pkg.sv | 26 ++
 rtl/seq_right_shifter_if.sv | 25 ++
 rtl/seq_right_shifter_shr_step.sv | 19 +
 rtl/seq_right_shifter.sv | 82 ++++++++
 tb/tb_seq_right_shifter.sv | 141 ++++++++++++++
 5 files changed

// File: rtl/seq_right_shifter_pkg.sv
// Shared types for the sequential right shifter: shift modes, FSM states
// and the input-mode normaliser.
package shifter_pkg;

    typedef enum logic [1:0] {
        SHR_LOGIC = 2'b00,
        SHR_ARITH = 2'b01,
        ROR       = 2'b10
    } shift_mode_t;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } shr_state_t;

    // The reserved encoding 2'b11 behaves as a logical shift.
    function automatic shift_mode_t to_mode(input logic [1:0] m);
        case (m)
            2'b01:   return SHR_ARITH;
            2'b10:   return ROR;
            default: return SHR_LOGIC;
        endcase
    endfunction

endpackage

// File: rtl/seq_right_shifter_if.sv
// Handshake bundle between producer/consumer (master) and the shifter (slave).
interface seq_right_shifter_if #(
    parameter int N = 2
);
    localparam int M = 2 ** N;

    logic         in_valid;
    logic         in_ready;
    logic [M-1:0] A;
    logic [N-1:0] shamt;
    logic [1:0]   mode;
    logic         out_valid;
    logic         out_ready;
    logic [M-1:0] Y;

    modport master (
        output in_valid, A, shamt, mode, out_ready,
        input  in_ready, out_valid, Y
    );

    modport slave (
        input  in_valid, A, shamt, mode, out_ready,
        output in_ready, out_valid, Y
    );
endinterface

// File: rtl/seq_right_shifter_shr_step.sv
// One-position right step of a word: logical, arithmetic or rotate.
module shr_step
    import shifter_pkg::*;
#(
    parameter int M = 4
) (
    input  logic [M-1:0] d,
    input  shift_mode_t  mode,
    output logic [M-1:0] q
);
    always_comb begin
        q = {1'b0, d[M-1:1]};
        case (mode)
            SHR_ARITH: q = {d[M-1], d[M-1:1]};
            ROR:       q = {d[0], d[M-1:1]};
            default:   q = {1'b0, d[M-1:1]};
        endcase
    end
endmodule

// File: rtl/seq_right_shifter.sv
// Multi-cycle right shifter/rotator: one bit position per clock, with
// valid/ready handshakes on both the operand and result sides.
module seq_right_shifter
    import shifter_pkg::*;
#(
    parameter int N = 2
) (
    input logic                 clk,
    input logic                 rst_n,
    seq_right_shifter_if.slave  bus
);
    localparam int M = 2 ** N;

    shr_state_t   state;
    logic [M-1:0] data_q;
    logic [N-1:0] cnt_q;
    shift_mode_t  mode_q;
    logic         in_ready_q;
    logic         out_valid_q;
    logic [M-1:0] step_d;

    shr_step #(.M(M)) u_step (
        .d    (data_q),
        .mode (mode_q),
        .q    (step_d)
    );

    // Handshake flags are registered alongside the state so they always
    // equal (state==IDLE) / (state==DONE) without a decode path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            data_q      <= '0;
            cnt_q       <= '0;
            mode_q      <= SHR_LOGIC;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        data_q     <= bus.A;
                        cnt_q      <= bus.shamt;
                        mode_q     <= to_mode(bus.mode);
                        in_ready_q <= 1'b0;
                        if (bus.shamt == '0) begin
                            state       <= DONE;
                            out_valid_q <= 1'b1;
                        end else begin
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    data_q <= step_d;
                    cnt_q  <= cnt_q - N'(1);
                    if (cnt_q == N'(1)) begin
                        state       <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.Y         = data_q;

endmodule

// File: tb/tb_seq_right_shifter.sv
// Directed self-checking bench for seq_right_shifter (N=2 and N=3 instances).
module tb_seq_right_shifter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    seq_right_shifter_if #(.N(2)) bus4 ();
    seq_right_shifter_if #(.N(3)) bus8 ();

    seq_right_shifter #(.N(2)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
    seq_right_shifter #(.N(3)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one op on bus4, then count cycles to out_valid with out_ready high.
    task automatic do_op(input string tag, input logic [3:0] a, input logic [1:0] sh,
                         input logic [1:0] md, input logic [3:0] exp_y);
        int k;
        bus4.A = a;
        bus4.shamt = sh;
        bus4.mode = md;
        bus4.out_ready = 1'b1;
        check({tag, "_in_ready"}, 32'(bus4.in_ready), 32'd1);
        bus4.in_valid = 1'b1;
        step();
        bus4.in_valid = 1'b0;
        bus4.A = 4'b0000;
        k = 1;
        while (!bus4.out_valid && k < 20) begin
            step();
            k++;
        end
        check({tag, "_latency"}, 32'(k), 32'(sh) + 32'd1);
        check({tag, "_y"}, 32'(bus4.Y), 32'(exp_y));
        step();
        check({tag, "_pulse"}, 32'(bus4.out_valid), 32'd0);
    endtask

    initial begin
        int k;
        bus4.in_valid = 1'b0; bus4.A = '0; bus4.shamt = '0; bus4.mode = '0; bus4.out_ready = 1'b0;
        bus8.in_valid = 1'b0; bus8.A = '0; bus8.shamt = '0; bus8.mode = '0; bus8.out_ready = 1'b0;
        #12;
        check("rst_out_valid", 32'(bus4.out_valid), 32'd0);
        check("rst_y", 32'(bus4.Y), 32'd0);
        check("rst_in_ready", 32'(bus4.in_ready), 32'd1);
        rst_n = 1'b1;
        step();

        do_op("logic_1011_s2", 4'b1011, 2'd2, 2'b00, 4'b0010);
        do_op("arith_1010_s3", 4'b1010, 2'd3, 2'b01, 4'b1111);
        do_op("arith_0110_s1", 4'b0110, 2'd1, 2'b01, 4'b0011);
        do_op("ror_1001_s1",   4'b1001, 2'd1, 2'b10, 4'b1100);
        do_op("ror_0110_s3",   4'b0110, 2'd3, 2'b10, 4'b1100);
        do_op("shamt0",        4'b0110, 2'd0, 2'b00, 4'b0110);
        do_op("mode11",        4'b1000, 2'd1, 2'b11, 4'b0100);

        // N=3 rotate by 7
        bus8.A = 8'h81; bus8.shamt = 3'd7; bus8.mode = 2'b10; bus8.out_ready = 1'b1;
        bus8.in_valid = 1'b1;
        step();
        bus8.in_valid = 1'b0;
        k = 1;
        while (!bus8.out_valid && k < 30) begin
            step();
            k++;
        end
        check("ror8_latency", 32'(k), 32'd8);
        check("ror8_y", 32'(bus8.Y), 32'h03);

        // Backpressure: hold result while a new op is offered
        bus4.A = 4'b0101; bus4.shamt = 2'd1; bus4.mode = 2'b00; bus4.out_ready = 1'b0;
        bus4.in_valid = 1'b1;
        step();
        bus4.A = 4'b1111; bus4.shamt = 2'd0; bus4.mode = 2'b01;
        step();
        check("bp_valid0", 32'(bus4.out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_y_hold", 32'(bus4.Y), 32'b0010);
            check("bp_valid_hold", 32'(bus4.out_valid), 32'd1);
            check("bp_in_ready", 32'(bus4.in_ready), 32'd0);
        end
        bus4.out_ready = 1'b1;
        step();
        check("bp_release_idle", 32'(bus4.in_ready), 32'd1);
        check("bp_release_valid", 32'(bus4.out_valid), 32'd0);
        step();
        bus4.in_valid = 1'b0;
        check("bp_second_valid", 32'(bus4.out_valid), 32'd1);
        check("bp_second_y", 32'(bus4.Y), 32'b1111);
        step();

        // Reset in the middle of a shift
        bus4.A = 4'b1111; bus4.shamt = 2'd3; bus4.mode = 2'b00; bus4.in_valid = 1'b1;
        step();
        bus4.in_valid = 1'b0;
        step();
        check("mid_in_shift", 32'(bus4.in_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(bus4.out_valid), 32'd0);
        check("mid_rst_y", 32'(bus4.Y), 32'd0);
        check("mid_rst_in_ready", 32'(bus4.in_ready), 32'd1);
        step();
        rst_n = 1'b1;
        k = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (bus4.out_valid) k++;
        end
        check("mid_no_stale", 32'(k), 32'd0);
        check("mid_y_zero", 32'(bus4.Y), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not reach its end");
        $fatal(1, "timeout");
    end

endmodule
